// File: rtl/inspection_sampler.sv
// Sensor front-end: debounces present/weight/size/color, settles each item, then grades a fixed window.
// Optional 2-flop input synchronizers when INSPECTION_SAMPLER_SYNC_EN is defined.
module inspection_sampler #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SETTLE_CYCLES   = 8,
    parameter int WINDOW_CYCLES   = 16,
    parameter int HIT_THRESHOLD   = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic present_raw_i,
    input  logic weight_raw_i,
    input  logic size_raw_i,
    input  logic color_raw_i,
    output logic weight_ok_o,
    output logic size_ok_o,
    output logic color_ok_o,
    output logic sample_valid_o,
    output logic busy_o
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int WW = $clog2(WINDOW_CYCLES + 1);
    localparam int HW = $clog2(WINDOW_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SETTLE     = 3'd1,
        MEASURE    = 3'd2,
        PUBLISH    = 3'd3,
        WAIT_CLEAR = 3'd4
    } state_t;

    // Bit order everywhere: 0 present, 1 weight, 2 size, 3 color.
    logic [3:0] raw_vec;
    logic [3:0] cond_vec;
    logic [3:0] db_vec;

    assign raw_vec = {color_raw_i, size_raw_i, weight_raw_i, present_raw_i};

`ifdef INSPECTION_SAMPLER_SYNC_EN
    logic [3:0] sync1_reg;
    logic [3:0] sync2_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw_vec;
            sync2_reg <= sync1_reg;
        end
    end

    assign cond_vec = sync2_reg;
`else
    assign cond_vec = raw_vec;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_db
            logic          db_reg;
            logic [DW-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    db_reg  <= 1'b0;
                    cnt_reg <= '0;
                end else if (cond_vec[gi] == db_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == DW'(DEBOUNCE_CYCLES - 1)) begin
                    db_reg  <= cond_vec[gi];
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign db_vec[gi] = db_reg;
        end
    endgenerate

    logic          db_present;
    logic [2:0]    db_sens;
    logic [HW-1:0] hit_reg [3];
    logic [HW-1:0] hit_next [3];
    logic [2:0]    final_ok;

    assign db_present = db_vec[0];
    assign db_sens    = db_vec[3:1];

    // The final window sample is folded in here so the verdict lands on the last MEASURE edge.
    generate
        for (gi = 0; gi < 3; gi++) begin : g_hit
            assign hit_next[gi] = hit_reg[gi] + HW'(db_sens[gi]);
            assign final_ok[gi] = (hit_next[gi] >= HW'(HIT_THRESHOLD));
        end
    endgenerate

    state_t        state_reg;
    logic [SW-1:0] settle_cnt_reg;
    logic [WW-1:0] win_cnt_reg;
    logic [2:0]    ok_reg;
    logic          valid_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            settle_cnt_reg <= '0;
            win_cnt_reg    <= '0;
            ok_reg         <= '0;
            valid_reg      <= 1'b0;
            for (int i = 0; i < 3; i++) hit_reg[i] <= '0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (db_present) begin
                        state_reg      <= SETTLE;
                        settle_cnt_reg <= '0;
                    end
                end
                SETTLE: begin
                    if (!db_present) begin
                        state_reg <= IDLE;
                    end else if (settle_cnt_reg == SW'(SETTLE_CYCLES - 1)) begin
                        state_reg   <= MEASURE;
                        win_cnt_reg <= '0;
                        for (int i = 0; i < 3; i++) hit_reg[i] <= '0;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + 1'b1;
                    end
                end
                MEASURE: begin
                    // Removal wins over a publish on the same edge.
                    if (!db_present) begin
                        state_reg <= IDLE;
                    end else begin
                        for (int i = 0; i < 3; i++) hit_reg[i] <= hit_next[i];
                        if (win_cnt_reg == WW'(WINDOW_CYCLES - 1)) begin
                            state_reg <= PUBLISH;
                            ok_reg    <= final_ok;
                            valid_reg <= 1'b1;
                        end else begin
                            win_cnt_reg <= win_cnt_reg + 1'b1;
                        end
                    end
                end
                PUBLISH: begin
                    state_reg <= WAIT_CLEAR;
                end
                WAIT_CLEAR: begin
                    if (!db_present) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign weight_ok_o    = ok_reg[0];
    assign size_ok_o      = ok_reg[1];
    assign color_ok_o     = ok_reg[2];
    assign sample_valid_o = valid_reg;
    assign busy_o         = (state_reg != IDLE);
endmodule
